// File: rtl/tdm_demux4.sv
// ---------------------------------------------------------------------------
// tdm_demux4
//
// Receive end of a 4:1 TDM link. The incoming stream carries slots in the
// order a, b, c, d. The slot-0 (channel a) sample is flagged by in_sync.
// The block hunts for a sync, checks framing for LOCK_FRAMES consecutive
// frames, and then delivers each complete frame as one registered 4-channel
// word with a one-cycle out_valid strobe.
//
// Parameters
//   DATA_W       width of one slot sample and of each channel output
//   LOCK_FRAMES  consecutive correctly framed frames needed to lock (1..15)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   in_valid     in_data / in_sync are accepted this cycle
//   in_data      current slot sample
//   in_sync      high only with the slot-0 sample
//   out_a..out_d channels of the last delivered frame
//   out_valid    one-cycle pulse when out_a..out_d take a new frame
//   slot         expected slot of the next accepted sample
//   locked       high while in LOCKED (registered from the state)
//   sync_err     one-cycle pulse on a framing violation
//   err_cnt      saturating count of sync_err pulses (optional, see below)
//
// Build option
//   TDM_DEMUX_ERR_CNT_EN  when defined, adds the 8-bit err_cnt output and
//                         its counter. When undefined, both are absent.
// ---------------------------------------------------------------------------
module tdm_demux4 #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sync,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic [DATA_W-1:0] out_d,
    output logic              out_valid,
    output logic [1:0]        slot,
    output logic              locked,
    output logic              sync_err
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    // Framing state encoding.
    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] LOCK_TH = 4'(LOCK_FRAMES);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [1:0]        slot_q, slot_d;
    logic [3:0]        good_cnt_q, good_cnt_d;
    logic [DATA_W-1:0] shadow_q [3];
    logic [DATA_W-1:0] out_a_q, out_b_q, out_c_q, out_d_q;
    logic              out_valid_q;
    logic              locked_q;
    logic              sync_err_q;

    // Per-cycle decode results
    logic [2:0]        shadow_we;
    logic              deliver;
    logic              frame_err;
    logic [3:0]        good_inc;

    // Saturating increment of the good-frame counter.
    always_comb begin
        good_inc = good_cnt_q;
        if (good_cnt_q != 4'hF) begin
            good_inc = good_cnt_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        good_cnt_d = good_cnt_q;
        shadow_we  = 3'b000;
        deliver    = 1'b0;
        frame_err  = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                ST_CHECK, ST_LOCKED: begin
                    if (slot_q != 2'd0 && !in_sync) begin
                        // In-frame sample at the expected position.
                        slot_d = slot_q + 2'd1;   // 3 wraps to 0
                        if (slot_q != 2'd3) begin
                            shadow_we[slot_q] = 1'b1;
                        end else if (state_q == ST_LOCKED) begin
                            // Whole frame was received while locked, since
                            // LOCKED is only ever entered at a slot-0 sample.
                            deliver = 1'b1;
                        end
                    end else if (slot_q == 2'd0 && in_sync) begin
                        // Correct frame boundary.
                        shadow_we[0] = 1'b1;
                        slot_d       = 2'd1;
                        if (state_q == ST_CHECK) begin
                            good_cnt_d = good_inc;
                            if (good_inc >= LOCK_TH) begin
                                state_d = ST_LOCKED;
                            end
                        end
                    end else if (in_sync) begin
                        // Early sync: realign on this sample straight away.
                        frame_err    = 1'b1;
                        shadow_we[0] = 1'b1;
                        slot_d       = 2'd1;
                        good_cnt_d   = 4'd0;
                        state_d      = ST_CHECK;
                    end else begin
                        // Missing sync at slot 0: drop the sample and hunt.
                        frame_err = 1'b1;
                        slot_d    = 2'd0;
                        state_d   = ST_HUNT;
                    end
                end
                default: begin
                    // HUNT (and any unused encoding): wait for a sync sample.
                    if (in_sync) begin
                        shadow_we[0] = 1'b1;
                        slot_d       = 2'd1;
                        good_cnt_d   = 4'd0;
                        state_d      = ST_CHECK;
                    end else begin
                        slot_d  = 2'd0;
                        state_d = ST_HUNT;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Framing state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            slot_q     <= 2'd0;
            good_cnt_q <= 4'd0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            good_cnt_q <= good_cnt_d;
            locked_q   <= (state_q == ST_LOCKED);
        end
    end

    // ------------------------------------------------------------------
    // Shadow capture of slots 0..2
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (shadow_we[i]) begin
                    shadow_q[i] <= in_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame delivery and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            out_d_q     <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            out_valid_q <= deliver;
            sync_err_q  <= frame_err;
            // Outputs keep the last frame across unlock; only rst clears.
            if (deliver) begin
                out_a_q <= shadow_q[0];
                out_b_q <= shadow_q[1];
                out_c_q <= shadow_q[2];
                out_d_q <= in_data;
            end
        end
    end

`ifdef TDM_DEMUX_ERR_CNT_EN
    // ------------------------------------------------------------------
    // Saturating framing-error counter
    // ------------------------------------------------------------------
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (frame_err && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_c     = out_c_q;
    assign out_d     = out_d_q;
    assign out_valid = out_valid_q;
    assign slot      = slot_q;
    assign locked    = locked_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_sync = 1'b0;
    logic [7:0] out_a, out_b, out_c, out_d;
    logic       out_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdm_demux4 #(
        .DATA_W      (8),
        .LOCK_FRAMES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sync   (in_sync),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_valid (out_valid),
        .slot      (slot),
        .locked    (locked),
        .sync_err  (sync_err)
`ifdef TDM_DEMUX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    typedef struct {
        bit          r;
        bit          v;
        bit          s;
        logic [7:0]  d;
        logic [1:0]  e_slot;
        bit          e_lk;
        bit          e_ov;
        bit          e_er;
        logic [31:0] e_out;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit v, input bit s, input logic [7:0] d,
                       input logic [1:0] sl, input bit lk, input bit ov, input bit er,
                       input logic [31:0] o);
        vec_t t;
        t.r = r; t.v = v; t.s = s; t.d = d;
        t.e_slot = sl; t.e_lk = lk; t.e_ov = ov; t.e_er = er; t.e_out = o;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic drive(input bit r, input bit v, input bit s, input logic [7:0] d);
        @(negedge clk);
        rst = r; in_valid = v; in_sync = s; in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input int idx, input vec_t t);
        chk("slot", idx, 32'(slot), 32'(t.e_slot));
        chk("locked", idx, 32'(locked), 32'(t.e_lk));
        chk("out_valid", idx, 32'(out_valid), 32'(t.e_ov));
        chk("sync_err", idx, 32'(sync_err), 32'(t.e_er));
        chk("out", idx, {out_a, out_b, out_c, out_d}, t.e_out);
    endtask

    localparam logic [31:0] Z = 32'h0;
    localparam logic [31:0] P = 32'hA1B2C3D4;
    localparam logic [31:0] Q = 32'h55667788;
    localparam logic [31:0] F = 32'hF1F2F3F4;

    initial begin
        // Reset, with a sync sample presented during the last reset cycle.
        add(1, 0, 0, 8'h00, 0, 0, 0, 0, Z);
        add(1, 0, 0, 8'h00, 0, 0, 0, 0, Z);
        add(1, 1, 1, 8'hA1, 0, 0, 0, 0, Z);
        // Three frames back to back: the lock completes at the third sync,
        // so only the third frame is delivered.
        for (int f = 0; f < 2; f++) begin
            add(0, 1, 1, 8'hA1, 1, 0, 0, 0, Z);
            add(0, 1, 0, 8'hB2, 2, 0, 0, 0, Z);
            add(0, 1, 0, 8'hC3, 3, 0, 0, 0, Z);
            add(0, 1, 0, 8'hD4, 0, 0, 0, 0, Z);
        end
        add(0, 1, 1, 8'hA1, 1, 0, 0, 0, Z);
        add(0, 1, 0, 8'hB2, 2, 1, 0, 0, Z);
        add(0, 1, 0, 8'hC3, 3, 1, 0, 0, Z);
        add(0, 1, 0, 8'hD4, 0, 1, 1, 0, P);
        // in_valid gaps inside a locked frame.
        add(0, 1, 1, 8'h55, 1, 1, 0, 0, P);
        add(0, 0, 0, 8'hEE, 1, 1, 0, 0, P);
        add(0, 1, 0, 8'h66, 2, 1, 0, 0, P);
        add(0, 0, 1, 8'hEE, 2, 1, 0, 0, P);
        add(0, 1, 0, 8'h77, 3, 1, 0, 0, P);
        add(0, 0, 0, 8'hEE, 3, 1, 0, 0, P);
        add(0, 1, 0, 8'h88, 0, 1, 1, 0, Q);
        add(0, 0, 0, 8'hEE, 0, 1, 0, 0, Q);
        // Early sync on slot 2: resync on 9A, broken frame never delivered.
        add(0, 1, 1, 8'h11, 1, 1, 0, 0, Q);
        add(0, 1, 0, 8'h22, 2, 1, 0, 0, Q);
        add(0, 1, 1, 8'h9A, 1, 1, 0, 1, Q);
        add(0, 0, 0, 8'hEE, 1, 0, 0, 0, Q);
        add(0, 1, 0, 8'h9B, 2, 0, 0, 0, Q);
        add(0, 1, 0, 8'h9C, 3, 0, 0, 0, Q);
        add(0, 1, 0, 8'h9D, 0, 0, 0, 0, Q);
        // Relock from the 9A alignment; F frame is the first delivered.
        add(0, 1, 1, 8'hE1, 1, 0, 0, 0, Q);
        add(0, 1, 0, 8'hE2, 2, 0, 0, 0, Q);
        add(0, 1, 0, 8'hE3, 3, 0, 0, 0, Q);
        add(0, 1, 0, 8'hE4, 0, 0, 0, 0, Q);
        add(0, 1, 1, 8'hF1, 1, 0, 0, 0, Q);
        add(0, 1, 0, 8'hF2, 2, 1, 0, 0, Q);
        add(0, 1, 0, 8'hF3, 3, 1, 0, 0, Q);
        add(0, 1, 0, 8'hF4, 0, 1, 1, 0, F);
        // Missing sync at slot 0: HUNT, outputs keep the last frame.
        add(0, 1, 0, 8'h77, 0, 1, 0, 1, F);
        add(0, 0, 0, 8'hEE, 0, 0, 0, 0, F);
        add(0, 1, 0, 8'h33, 0, 0, 0, 0, F);
        // Relock, then reset after slot 1 of a locked frame.
        add(0, 1, 1, 8'h61, 1, 0, 0, 0, F);
        add(0, 1, 0, 8'h62, 2, 0, 0, 0, F);
        add(0, 1, 0, 8'h63, 3, 0, 0, 0, F);
        add(0, 1, 0, 8'h64, 0, 0, 0, 0, F);
        add(0, 1, 1, 8'h71, 1, 0, 0, 0, F);
        add(0, 1, 0, 8'h72, 2, 0, 0, 0, F);
        add(0, 1, 0, 8'h73, 3, 0, 0, 0, F);
        add(0, 1, 0, 8'h74, 0, 0, 0, 0, F);
        add(0, 1, 1, 8'h81, 1, 0, 0, 0, F);
        add(0, 1, 0, 8'h82, 2, 1, 0, 0, F);
        add(1, 1, 0, 8'h83, 0, 0, 0, 0, Z);
        add(0, 1, 0, 8'h84, 0, 0, 0, 0, Z);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].d);
            check_vec(i, vecs[i]);
        end

        // Long idle stretch mid-frame: everything holds, no pulses.
        drive(0, 1, 1, 8'h5A);
        chk("hold_slot_start", 0, 32'(slot), 32'd1);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 8'hFF);
            chk("hold_slot", i, 32'(slot), 32'd1);
            chk("hold_err", i, 32'(sync_err), 32'd0);
            chk("hold_ov", i, 32'(out_valid), 32'd0);
        end
        drive(0, 1, 0, 8'h5B);
        chk("hold_resume", 0, 32'(slot), 32'd2);

`ifdef TDM_DEMUX_ERR_CNT_EN
        drive(1, 0, 0, 8'h00);
        chk("err_cnt_rst", 0, 32'(err_cnt), 32'd0);
        drive(0, 1, 1, 8'h01);
        // Each further sync lands on slot 1: an early-sync violation.
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 1, 8'h01);
        end
        chk("err_cnt_sat", 0, 32'(err_cnt), 32'hFF);
        chk("err_pulse", 0, 32'(sync_err), 32'd1);
        drive(1, 0, 0, 8'h00);
        chk("err_cnt_clr", 0, 32'(err_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
